// File: rtl/mac_pkg.sv
// Shared encodings and saturation-bound helpers for the MAC accumulator datapath.
// Bounds are returned as 64-bit words; callers keep the low w bits.
package mac_pkg;

  typedef enum logic {
    MAC_MODE_UNSIGNED = 1'b0,
    MAC_MODE_SIGNED   = 1'b1
  } mac_mode_e;

  localparam int MAC_MAX_W = 64;

  typedef logic [MAC_MAX_W-1:0] mac_word_t;

  // Largest representable value of a w-bit accumulator.
  function automatic mac_word_t sat_max(input int w, input logic is_signed);
    mac_word_t r;
    int        ones;
    r    = '0;
    ones = is_signed ? w - 1 : w;
    for (int i = 0; i < MAC_MAX_W; i++) begin
      if (i < ones) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable value of a w-bit accumulator.
  function automatic mac_word_t sat_min(input int w, input logic is_signed);
    mac_word_t r;
    r = '0;
    if (is_signed) begin
      for (int i = 0; i < MAC_MAX_W; i++) begin
        if (i >= w - 1) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulate step: extends the product to ACC_W bits, adds it to the
// accumulator, flags overflow and optionally clamps to the bound that was crossed.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PW     = 16,
  parameter int ACC_W  = 20,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [PW-1:0]    prod,
  input  logic             is_signed,
  output logic [ACC_W-1:0] sum_out,
  output logic             ovf
);

  localparam mac_word_t MAX_S_W = sat_max(ACC_W, 1'b1);
  localparam mac_word_t MAX_U_W = sat_max(ACC_W, 1'b0);
  localparam mac_word_t MIN_S_W = sat_min(ACC_W, 1'b1);
  localparam mac_word_t MIN_U_W = sat_min(ACC_W, 1'b0);

  localparam logic [ACC_W-1:0] MAX_S = MAX_S_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MAX_U = MAX_U_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_S = MIN_S_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_U = MIN_U_W[ACC_W-1:0];

  logic             fill;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   sum_x;
  logic             overflow_hi;

  assign fill = is_signed & prod[PW-1];

  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_ext
      if (gi < PW) begin : g_bit
        assign prod_ext[gi] = prod[gi];
      end else begin : g_fill
        assign prod_ext[gi] = fill;
      end
    end
  endgenerate

  // One guard bit is enough to see both signed and unsigned overflow.
  always_comb begin
    acc_x       = {is_signed & acc_in[ACC_W-1], acc_in};
    prod_x      = {fill, prod_ext};
    sum_x       = acc_x + prod_x;
    ovf         = 1'b0;
    overflow_hi = 1'b1;
    if (is_signed) begin
      ovf         = sum_x[ACC_W] ^ sum_x[ACC_W-1];
      overflow_hi = ~sum_x[ACC_W];
    end else begin
      ovf         = sum_x[ACC_W];
      overflow_hi = 1'b1;
    end
  end

  always_comb begin
    sum_out = sum_x[ACC_W-1:0];
    if (SAT_EN && ovf) begin
      if (overflow_hi) sum_out = is_signed ? MAX_S : MAX_U;
      else             sum_out = is_signed ? MIN_S : MIN_U;
    end
  end

endmodule

// File: rtl/mac_accum_pipe.sv
// Two-stage multiply-accumulate core: stage 1 registers the product, stage 2 folds it
// into the accumulator and publishes a framed result on the last beat.
module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  result,
  output logic              out_valid,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $error("mac_accum_pipe: ACC_W must be >= 2*DATA_W");
    end
    if (ACC_W > MAC_MAX_W) begin : g_bad_acc_max
      $error("mac_accum_pipe: ACC_W exceeds MAC_MAX_W");
    end
  endgenerate

  logic             v1_q, v1_d;
  logic             last1_q, last1_d;
  mac_mode_e        mode1_q, mode1_d;
  logic [PW-1:0]    p_q, p_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  assign accept = in_valid & ena & ~clr;

  // Extending to PW bits first lets one multiplier serve both modes: the low PW bits
  // of the extended product are the exact signed or unsigned result.
  always_comb begin
    a_ext = signed_mode ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    b_ext = signed_mode ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

  mac_sat_add #(
    .PW     (PW),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .acc_in    (acc_q),
    .prod      (p_q),
    .is_signed (mode1_q == MAC_MODE_SIGNED),
    .sum_out   (sum),
    .ovf       (sum_ovf)
  );

  always_comb begin
    v1_d        = v1_q;
    last1_d     = last1_q;
    mode1_d     = mode1_q;
    p_d         = p_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (ena) begin
      if (clr) begin
        v1_d        = 1'b0;
        acc_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
      end else begin
        v1_d        = accept;
        out_valid_d = 1'b0;
        if (accept) begin
          p_d     = prod;
          last1_d = in_last;
          mode1_d = signed_mode ? MAC_MODE_SIGNED : MAC_MODE_UNSIGNED;
        end
        if (v1_q) begin
          if (sum_ovf) ovf_d = 1'b1;
          // The closing beat restarts the accumulator so the next frame can follow directly.
          if (last1_q) begin
            result_d    = sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
          end else begin
            acc_d = sum;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      mode1_q     <= MAC_MODE_UNSIGNED;
      p_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      mode1_q     <= mode1_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign acc       = acc_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q & ena;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed bench for mac_accum_pipe: a saturating and a wrapping instance share
// the same stimulus; each scenario task checks its own hand-computed results.
module tb_mac_accum_pipe;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        in_last;
  logic        signed_mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        clr;

  logic [19:0] acc, result;
  logic        out_valid, ovf;
  logic [19:0] acc_w, result_w;
  logic        out_valid_w, ovf_w;

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;

  mac_accum_pipe #(.DATA_W(8), .ACC_W(20), .SAT_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .clr         (clr),
    .acc         (acc),
    .result      (result),
    .out_valid   (out_valid),
    .ovf         (ovf)
  );

  mac_accum_pipe #(.DATA_W(8), .ACC_W(20), .SAT_EN(1'b0)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .clr         (clr),
    .acc         (acc_w),
    .result      (result_w),
    .out_valid   (out_valid_w),
    .ovf         (ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [7:0] ta, input logic [7:0] tb,
                            input logic tl, input logic tm);
    a           = ta;
    b           = tb;
    in_last     = tl;
    signed_mode = tm;
    in_valid    = 1'b1;
    tick(1);
    in_valid    = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    signed_mode = 1'b0; a = '0; b = '0; clr = 1'b0;
    tick(2);
    total++;
    if ({acc, result, out_valid, ovf} !== 42'd0) begin
      bad++;
      $display("FAIL reset_state: acc=%0d result=%0d out_valid=%b ovf=%b, required all 0",
               acc, result, out_valid, ovf);
    end
    rst_n = 1'b1;
    tick(1);
    $display("reset released");
  endtask

  task automatic test_signed_frame();
    int ov0;
    do_clr();
    ov0 = ov_cnt;
    drive_beat(8'd3, 8'd2, 1'b0, 1'b1);
    drive_beat(8'd1, 8'd4, 1'b0, 1'b1);
    drive_beat(8'd5, 8'd3, 1'b0, 1'b1);
    drive_beat(8'd7, 8'd2, 1'b1, 1'b1);
    total++;
    if (acc !== 20'd25) begin
      bad++; $display("FAIL signed_acc_mid: acc=%0d required 25", acc);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL signed_early_valid: out_valid=%b required 0", out_valid);
    end
    tick(1);
    total++;
    if (out_valid !== 1'b1 || result !== 20'd39) begin
      bad++; $display("FAIL signed_result: out_valid=%b result=%0d required 1/39", out_valid, result);
    end
    total++;
    if (ovf !== 1'b0 || acc !== 20'd0) begin
      bad++; $display("FAIL signed_after: ovf=%b acc=%0d required 0/0", ovf, acc);
    end
    tick(1);
    total++;
    if (ov_cnt - ov0 !== 1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL signed_pulse: pulses=%0d out_valid=%b required 1/0", ov_cnt - ov0, out_valid);
    end
    $display("signed frame: result=%0d ovf=%b", result, ovf);
  endtask

  task automatic test_unsigned_sat();
    do_clr();
    for (int i = 0; i < 16; i++) drive_beat(8'd255, 8'd255, (i == 15), 1'b0);
    tick(1);
    total++;
    if (out_valid !== 1'b1 || result !== 20'd1040400 || ovf !== 1'b0) begin
      bad++; $display("FAIL unsigned_16: out_valid=%b result=%0d ovf=%b required 1/1040400/0",
                      out_valid, result, ovf);
    end
    $display("unsigned 16 beats: result=%0d ovf=%b", result, ovf);
    do_clr();
    for (int i = 0; i < 17; i++) drive_beat(8'd255, 8'd255, (i == 16), 1'b0);
    tick(1);
    total++;
    if (out_valid !== 1'b1 || result !== 20'd1048575 || ovf !== 1'b1) begin
      bad++; $display("FAIL unsigned_17_sat: out_valid=%b result=%0d ovf=%b required 1/1048575/1",
                      out_valid, result, ovf);
    end
    total++;
    if (result_w !== 20'd56849 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL unsigned_17_wrap: result=%0d ovf=%b required 56849/1", result_w, ovf_w);
    end
    $display("unsigned 17 beats: sat=%0d wrap=%0d ovf=%b", result, result_w, ovf);
  endtask

  task automatic test_signed_sat();
    do_clr();
    for (int i = 0; i < 33; i++) drive_beat(8'h80, 8'h7F, (i == 32), 1'b1);
    tick(1);
    total++;
    if (out_valid !== 1'b1 || result !== 20'h80000 || ovf !== 1'b1) begin
      bad++; $display("FAIL signed_sat: out_valid=%b result=%h ovf=%b required 1/80000/1",
                      out_valid, result, ovf);
    end
    total++;
    if (out_valid_w !== 1'b1 || result_w !== 20'd512128 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL signed_wrap: out_valid=%b result=%0d ovf=%b required 1/512128/1",
                      out_valid_w, result_w, ovf_w);
    end
    $display("signed 33 beats: sat=%h wrap=%0d ovf=%b", result, result_w, ovf);
  endtask

  task automatic test_clr_in_flight();
    int ov0;
    do_clr();
    ov0 = ov_cnt;
    drive_beat(8'd3, 8'd2, 1'b0, 1'b1);
    drive_beat(8'd1, 8'd4, 1'b1, 1'b1);
    do_clr();
    total++;
    if (acc !== 20'd0 || ovf !== 1'b0) begin
      bad++; $display("FAIL clr_state: acc=%0d ovf=%b required 0/0", acc, ovf);
    end
    tick(3);
    total++;
    if (ov_cnt !== ov0 || result !== 20'h80000 || acc !== 20'd0) begin
      bad++; $display("FAIL clr_dropped: pulses=%0d result=%h acc=%0d required 0/80000/0",
                      ov_cnt - ov0, result, acc);
    end
    $display("clr in flight: result=%h acc=%0d", result, acc);
  endtask

  task automatic test_ena_freeze();
    int ov0;
    do_clr();
    ov0 = ov_cnt;
    drive_beat(8'd3, 8'd2, 1'b0, 1'b1);
    drive_beat(8'd1, 8'd4, 1'b0, 1'b1);
    ena = 1'b0; a = 8'd99; b = 8'd99; in_valid = 1'b1;
    tick(3);
    total++;
    if (acc !== 20'd6 || out_valid !== 1'b0) begin
      bad++; $display("FAIL freeze_hold: acc=%0d out_valid=%b required 6/0", acc, out_valid);
    end
    in_valid = 1'b0;
    ena = 1'b1;
    drive_beat(8'd5, 8'd3, 1'b0, 1'b1);
    drive_beat(8'd7, 8'd2, 1'b1, 1'b1);
    tick(1);
    ena = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 20'd39) begin
      bad++; $display("FAIL freeze_mask: out_valid=%b result=%0d required 0/39", out_valid, result);
    end
    tick(2);
    ena = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL freeze_release: out_valid=%b required 1", out_valid);
    end
    tick(1);
    total++;
    if (out_valid !== 1'b0 || ov_cnt - ov0 !== 1) begin
      bad++; $display("FAIL freeze_pulse: out_valid=%b pulses=%0d required 0/1", out_valid, ov_cnt - ov0);
    end
    $display("ena freeze frame: result=%0d", result);
  endtask

  task automatic test_async_reset();
    do_clr();
    drive_beat(8'd3, 8'd2, 1'b0, 1'b1);
    drive_beat(8'd1, 8'd4, 1'b0, 1'b1);
    drive_beat(8'd5, 8'd3, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({acc, result, out_valid, ovf} !== 42'd0) begin
      bad++; $display("FAIL async_reset: acc=%0d result=%0d out_valid=%b ovf=%b required all 0",
                      acc, result, out_valid, ovf);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    drive_beat(8'd2, 8'd2, 1'b1, 1'b1);
    tick(1);
    total++;
    if (out_valid !== 1'b1 || result !== 20'd4) begin
      bad++; $display("FAIL post_reset_frame: out_valid=%b result=%0d required 1/4", out_valid, result);
    end
    $display("post-reset frame: result=%0d", result);
  endtask

  initial begin
    test_reset();
    test_signed_frame();
    test_unsigned_sat();
    test_signed_sat();
    test_clr_in_flight();
    test_ena_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
